// File: rtl/sig_debounce.sv
`timescale 1ns/1ps
// sig_debounce: synchronizes a raw asynchronous level and accepts a new level
// only after it has held for DEBOUNCE_CNT consecutive clk cycles. Changes that
// end before qualification completes are counted as glitches (saturating).
module sig_debounce #(
  parameter int SYNC_STAGES  = 2,    // 2..4
  parameter int DEBOUNCE_CNT = 1000  // 1..65535
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sig,
  input  logic       glitchClr,
  output logic       sigClean,
  output logic       settling,
  output logic [7:0] glitchCnt
);

  localparam int CNT_W = $clog2(DEBOUNCE_CNT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {
    STABLE_LOW,
    CHK_HIGH,
    STABLE_HIGH,
    CHK_LOW
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sig_sync;
  state_t                 state, state_d;
  logic [CNT_W-1:0]       cnt, cnt_d;
  logic                   glitch_evt;

  assign sig_sync = sync_q[SYNC_STAGES-1];

  // Synchronizer chain: shifts the raw input toward sig_sync, stage 0 first.
  // NOTE: every flop in the chain is reset so no stale level leaks out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      // NOTE: sequential state uses <= so all flops update from pre-edge values.
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig};
    end
  end

  // Next-state, counter and glitch-event logic for the qualification FSM.
  always_comb begin
    // NOTE: defaults first so every path assigns every output (no latches).
    state_d    = state;
    cnt_d      = cnt;
    glitch_evt = 1'b0;
    unique case (state)
      STABLE_LOW: begin
        if (sig_sync) begin
          state_d = CHK_HIGH;
          cnt_d   = '0;
        end
      end
      CHK_HIGH: begin
        if (!sig_sync) begin
          state_d    = STABLE_LOW;
          cnt_d      = '0;
          glitch_evt = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_d = STABLE_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      STABLE_HIGH: begin
        if (!sig_sync) begin
          state_d = CHK_LOW;
          cnt_d   = '0;
        end
      end
      CHK_LOW: begin
        if (sig_sync) begin
          state_d    = STABLE_HIGH;
          cnt_d      = '0;
          glitch_evt = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_d = STABLE_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_d = STABLE_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and registered outputs decoded from the next state so they
  // change on the same edge as the state itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= STABLE_LOW;
      cnt      <= '0;
      sigClean <= 1'b0;
      settling <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      sigClean <= (state_d == STABLE_HIGH) || (state_d == CHK_LOW);
      settling <= (state_d == CHK_HIGH)    || (state_d == CHK_LOW);
    end
  end

  // Saturating glitch counter; a clear on the same edge as a glitch wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitchCnt <= '0;
    end else if (glitchClr) begin
      glitchCnt <= '0;
    end else if (glitch_evt && (glitchCnt != 8'hFF)) begin
      glitchCnt <= glitchCnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_sig_debounce.sv
`timescale 1ns/1ps
// tb_sig_debounce: directed table plus hand sequences for sig_debounce with
// SYNC_STAGES=2, DEBOUNCE_CNT=4 (qualification latency 7 edges).
module tb_sig_debounce;

  logic       clk;
  logic       rst_n;
  logic       sig;
  logic       glitchClr;
  logic       sigClean;
  logic       settling;
  logic [7:0] glitchCnt;

  int n_cmp;
  int n_bad;

  sig_debounce #(
    .SYNC_STAGES (2),
    .DEBOUNCE_CNT(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sig      (sig),
    .glitchClr(glitchClr),
    .sigClean (sigClean),
    .settling (settling),
    .glitchCnt(glitchCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       sig;
    logic       clr;
    logic       clean;
    logic       settle;
    logic [7:0] glitch;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive inputs just after an edge, then advance one edge and settle 1ns.
  task automatic step(input logic s, input logic c);
    sig       = s;
    glitchClr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic s);
    sig       = s;
    glitchClr = 1'b0;
    rst_n     = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Two-cycle high pulse then three low cycles from STABLE_LOW; the glitch is
  // recorded on the edge of step index 4. clr_at selects a step for glitchClr.
  task automatic pulse(input int clr_at);
    for (int i = 0; i < 5; i++) step(i < 2, i == clr_at);
  endtask

  int   exp_g;
  int   rises;
  logic prev_clean;
  logic exp_clean;

  initial begin
    n_cmp = 0;
    n_bad = 0;

    // edge: sig clr | clean settling glitch
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0};  // e1 stage0 takes 1
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0};  // e2 sigSync=1
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'd0};  // e3 CHK_HIGH cnt0
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'd0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'd0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'd0};  // e6 cnt3
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd0};  // e7 STABLE_HIGH
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0};  // 3-cycle low dip starts
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd0};  // e11 CHK_LOW
    vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'd0};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'd0};
    vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd1};  // e14 abort -> glitch
    vecs[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd1};
    vecs[15] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd0};  // clear alone

    // Reset state while held in reset.
    sig = 1'b0; glitchClr = 1'b0; rst_n = 1'b0;
    #12;
    check("rst_clean",  {7'd0, sigClean}, 8'd0);
    check("rst_settle", {7'd0, settling}, 8'd0);
    check("rst_glitch", glitchCnt, 8'd0);
    do_reset(1'b0);

    // Rise latency, settling window, then a rejected 3-cycle dip and a clear.
    for (int i = 0; i < 16; i++) begin
      step(vecs[i].sig, vecs[i].clr);
      check($sformatf("tbl%0d_clean", i + 1),  {7'd0, sigClean}, {7'd0, vecs[i].clean});
      check($sformatf("tbl%0d_settle", i + 1), {7'd0, settling}, {7'd0, vecs[i].settle});
      check($sformatf("tbl%0d_glitch", i + 1), glitchCnt, vecs[i].glitch);
    end

    // Full 0->1->0 cycle with 10-cycle holds; clean high on edges 7..16.
    do_reset(1'b0);
    rises = 0;
    prev_clean = 1'b0;
    for (int e = 1; e <= 30; e++) begin
      step(e <= 10, 1'b0);
      exp_clean = (e >= 7) && (e <= 16);
      check($sformatf("cyc_e%0d_clean", e), {7'd0, sigClean}, {7'd0, exp_clean});
      if (sigClean && !prev_clean) rises++;
      prev_clean = sigClean;
    end
    check("cyc_rises", rises[7:0], 8'd1);
    check("cyc_glitch", glitchCnt, 8'd0);

    // Reset asserted mid-qualification (CHK_HIGH, counter 2), no clk edge.
    do_reset(1'b0);
    for (int e = 1; e <= 5; e++) step(1'b1, 1'b0);
    check("midrst_pre_settle", {7'd0, settling}, 8'd1);
    sig = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("midrst_clean",  {7'd0, sigClean}, 8'd0);
    check("midrst_settle", {7'd0, settling}, 8'd0);
    check("midrst_glitch", glitchCnt, 8'd0);
    #1 rst_n = 1'b1;
    for (int e = 1; e <= 10; e++) step(1'b0, 1'b0);
    check("midrst_post_clean",  {7'd0, sigClean}, 8'd0);
    check("midrst_post_settle", {7'd0, settling}, 8'd0);
    check("midrst_post_glitch", glitchCnt, 8'd0);

    // sig already high at reset release: rises on edge 7, no glitch.
    do_reset(1'b1);
    for (int e = 1; e <= 6; e++) step(1'b1, 1'b0);
    check("hirel_e6_clean", {7'd0, sigClean}, 8'd0);
    step(1'b1, 1'b0);
    check("hirel_e7_clean", {7'd0, sigClean}, 8'd1);
    check("hirel_glitch", glitchCnt, 8'd0);

    // 300 short pulses: counter saturates at 255, clean never rises.
    do_reset(1'b0);
    exp_g = 0;
    for (int p = 0; p < 300; p++) begin
      pulse(-1);
      if (exp_g < 255) exp_g++;
      check($sformatf("sat_p%0d_glitch", p), glitchCnt, exp_g[7:0]);
      check($sformatf("sat_p%0d_clean", p), {7'd0, sigClean}, 8'd0);
    end

    // Clear, count to 5, then clear coinciding with a CHK_HIGH abort.
    step(1'b0, 1'b1);
    check("clr_alone", glitchCnt, 8'd0);
    for (int p = 0; p < 5; p++) pulse(-1);
    check("clr_five", glitchCnt, 8'd5);
    for (int i = 0; i < 5; i++) begin
      step(i < 2, i == 4);
      if (i == 3) check("clr_pre_settle", {7'd0, settling}, 8'd1);
    end
    check("clr_win", glitchCnt, 8'd0);
    check("clr_win_settle", {7'd0, settling}, 8'd0);
    step(1'b0, 1'b0);
    check("clr_hold", glitchCnt, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
